// File: rtl/tx_packet_sched.sv
// rtl/tx_packet_sched.sv - round-robin scheduler for the shared USB serial TX path
// Grants token/data/handshake sources, paces their PISO bit by bit, then frames EOP and gap.
module tx_packet_sched #(
  parameter int LEN_W   = 10,
  parameter int EOP_CYC = 2,
  parameter int GAP_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tok_req,
  input  logic [LEN_W-1:0] tok_len,
  input  logic             dat_req,
  input  logic [LEN_W-1:0] dat_len,
  input  logic             hs_req,
  input  logic [LEN_W-1:0] hs_len,
  output logic             tok_gnt,
  output logic             dat_gnt,
  output logic             hs_gnt,
  output logic [1:0]       sel,
  output logic             shift,
  output logic             eop,
  output logic             busy,
  output logic             pkt_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_SEND  = 3'd2,
    S_EOP   = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam int PH_W = 8;
  localparam logic [PH_W-1:0] EOP_LAST = PH_W'(EOP_CYC - 1);
  localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_CYC - 1);

  // Source indices: 0 token, 1 data, 2 handshake
  localparam logic [1:0] SRC_TOK = 2'd0;
  localparam logic [1:0] SRC_DAT = 2'd1;
  localparam logic [1:0] SRC_HS  = 2'd2;

  state_t            state_q, state_d;
  logic [1:0]        ptr_q;
  logic [1:0]        win_q;
  logic [1:0]        win;
  logic [1:0]        sel_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  grant_len;
  logic [PH_W-1:0]   ph_q;
  logic              any_req;

  function automatic logic [1:0] sel_code(input logic [1:0] src);
    case (src)
      SRC_DAT: sel_code = 2'b11;
      SRC_HS:  sel_code = 2'b10;
      default: sel_code = 2'b01;
    endcase
  endfunction

  // Round-robin: first requester found searching from the pointer onward
  always_comb begin
    any_req = tok_req | dat_req | hs_req;
    win     = SRC_TOK;
    case (ptr_q)
      SRC_DAT: win = dat_req ? SRC_DAT : (hs_req  ? SRC_HS  : SRC_TOK);
      SRC_HS:  win = hs_req  ? SRC_HS  : (tok_req ? SRC_TOK : SRC_DAT);
      default: win = tok_req ? SRC_TOK : (dat_req ? SRC_DAT : SRC_HS);
    endcase
  end

  always_comb begin
    case (win_q)
      SRC_DAT: grant_len = dat_len;
      SRC_HS:  grant_len = hs_len;
      default: grant_len = tok_len;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= SRC_TOK;
      win_q   <= SRC_TOK;
      sel_q   <= 2'b01;
      len_q   <= '0;
      cnt_q   <= '0;
      ph_q    <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= (state_d == state_q) ? ph_q + PH_W'(1) : '0;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            win_q <= win;
            sel_q <= sel_code(win);
          end
        end
        S_GRANT: begin
          len_q <= grant_len;
          cnt_q <= '0;
          ptr_q <= (win_q == SRC_HS) ? SRC_TOK : win_q + 2'd1;
        end
        S_SEND: cnt_q <= cnt_q + LEN_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_GRANT;
      S_GRANT: state_d = (grant_len == '0) ? S_EOP : S_SEND;
      S_SEND:  if (cnt_q == len_q - LEN_W'(1)) state_d = S_EOP;
      S_EOP:   if (ph_q == EOP_LAST) state_d = (GAP_CYC == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (ph_q == GAP_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tok_gnt  = (state_q == S_GRANT) && (win_q == SRC_TOK);
    dat_gnt  = (state_q == S_GRANT) && (win_q == SRC_DAT);
    hs_gnt   = (state_q == S_GRANT) && (win_q == SRC_HS);
    sel      = sel_q;
    shift    = (state_q == S_SEND);
    eop      = (state_q == S_EOP);
    busy     = (state_q != S_IDLE);
    pkt_done = ((state_q == S_GAP) && (ph_q == GAP_LAST)) ||
               ((GAP_CYC == 0) && (state_q == S_EOP) && (ph_q == EOP_LAST));
  end

endmodule

// File: tb/tb_tx_packet_sched.sv
// tb/tb_tx_packet_sched.sv - directed self-checking bench for tx_packet_sched
// Each scenario task drives requests and compares observed packet framing against hand-computed values.
module tb_tx_packet_sched;

  localparam int LEN_W = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tok_req, dat_req, hs_req;
  logic [LEN_W-1:0] tok_len, dat_len, hs_len;
  logic             tok_gnt, dat_gnt, hs_gnt;
  logic [1:0]       sel;
  logic             shift, eop, busy, pkt_done;

  int ntests = 0;
  int nfail  = 0;

  int         o_which, o_wait, o_shift, o_eop, o_gap, o_done, o_gnt, o_g2s;
  logic [1:0] o_sel;
  bit         o_sel_ok;

  tx_packet_sched #(.LEN_W(LEN_W), .EOP_CYC(2), .GAP_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .tok_req(tok_req), .tok_len(tok_len),
    .dat_req(dat_req), .dat_len(dat_len),
    .hs_req(hs_req), .hs_len(hs_len),
    .tok_gnt(tok_gnt), .dat_gnt(dat_gnt), .hs_gnt(hs_gnt),
    .sel(sel), .shift(shift), .eop(eop), .busy(busy), .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Follows one packet from its grant to pkt_done, sampling on falling edges.
  // o_which encodes the grant as {hs,dat,tok}; hold keeps the request asserted.
  task automatic observe_pkt(input bit hold, input bit chg_len);
    bit got;
    int gc;
    got = 0; gc = 0;
    o_which = 0; o_wait = -1; o_shift = 0; o_eop = 0; o_gap = 0;
    o_done = 0; o_gnt = 0; o_g2s = -1; o_sel = 2'bxx; o_sel_ok = 1;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (!got) begin
        if (tok_gnt | dat_gnt | hs_gnt) begin
          got = 1; gc = c; o_wait = c; o_gnt = 1; o_sel = sel;
          o_which = int'({hs_gnt, dat_gnt, tok_gnt});
          if (!hold) begin
            if (tok_gnt) tok_req = 1'b0;
            if (dat_gnt) dat_req = 1'b0;
            if (hs_gnt)  hs_req  = 1'b0;
          end
        end
      end else begin
        if (tok_gnt | dat_gnt | hs_gnt) o_gnt++;
        if (sel !== o_sel) o_sel_ok = 0;
        if (shift) begin
          o_shift++;
          if (o_g2s < 0) begin
            o_g2s = c - gc;
            if (chg_len) tok_len = 10'd5;
          end
        end
        if (eop) o_eop++;
        if (busy && !shift && !eop) o_gap++;
        if (pkt_done) begin
          o_done++;
          break;
        end
      end
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tok_req = 0; dat_req = 0; hs_req = 0;
    tok_len = '0; dat_len = '0; hs_len = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tok_req = 0; dat_req = 0; hs_req = 0;
    tok_len = '0; dat_len = '0; hs_len = '0;
    @(negedge clk);
    ntests++; if ({tok_gnt, dat_gnt, hs_gnt} !== 3'b000) begin nfail++; $display("FAIL reset_gnt: got %b want 000", {tok_gnt, dat_gnt, hs_gnt}); end
    ntests++; if (sel !== 2'b01) begin nfail++; $display("FAIL reset_sel: got %b want 01", sel); end
    ntests++; if ({shift, eop, busy, pkt_done} !== 4'b0000) begin nfail++; $display("FAIL reset_ctl: got %b want 0000", {shift, eop, busy, pkt_done}); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    ntests++; if ({busy, tok_gnt, dat_gnt, hs_gnt} !== 4'b0000) begin nfail++; $display("FAIL idle_no_req: got %b want 0000", {busy, tok_gnt, dat_gnt, hs_gnt}); end
  endtask

  task automatic test_single_token;
    tok_len = 10'd32; tok_req = 1'b1;
    observe_pkt(0, 0);
    ntests++; if (o_which !== 1) begin nfail++; $display("FAIL tok_which: got %0d want 1", o_which); end
    ntests++; if (o_wait !== 1) begin nfail++; $display("FAIL tok_req_to_gnt: got %0d want 1", o_wait); end
    ntests++; if (o_g2s !== 1) begin nfail++; $display("FAIL tok_gnt_to_shift: got %0d want 1", o_g2s); end
    ntests++; if (o_shift !== 32) begin nfail++; $display("FAIL tok_shift_cnt: got %0d want 32", o_shift); end
    ntests++; if (o_eop !== 2) begin nfail++; $display("FAIL tok_eop_cnt: got %0d want 2", o_eop); end
    ntests++; if (o_gap !== 1) begin nfail++; $display("FAIL tok_gap_cnt: got %0d want 1", o_gap); end
    ntests++; if (o_done !== 1) begin nfail++; $display("FAIL tok_pkt_done: got %0d want 1", o_done); end
    ntests++; if (o_gnt !== 1) begin nfail++; $display("FAIL tok_gnt_count: got %0d want 1", o_gnt); end
    ntests++; if (o_sel !== 2'b01 || !o_sel_ok) begin nfail++; $display("FAIL tok_sel: got %b stable=%0d want 01 stable=1", o_sel, o_sel_ok); end
  endtask

  task automatic test_all_three;
    int         exp_which [3] = '{1, 2, 4};
    logic [1:0] exp_sel   [3] = '{2'b01, 2'b11, 2'b10};
    int         exp_len   [3] = '{32, 8, 16};
    do_reset();
    tok_len = 10'd32; dat_len = 10'd8; hs_len = 10'd16;
    tok_req = 1; dat_req = 1; hs_req = 1;
    for (int k = 0; k < 3; k++) begin
      observe_pkt(0, 0);
      ntests++; if (o_which !== exp_which[k]) begin nfail++; $display("FAIL all3_which[%0d]: got %0d want %0d", k, o_which, exp_which[k]); end
      ntests++; if (o_sel !== exp_sel[k] || !o_sel_ok) begin nfail++; $display("FAIL all3_sel[%0d]: got %b want %b", k, o_sel, exp_sel[k]); end
      ntests++; if (o_shift !== exp_len[k] || o_eop !== 2 || o_done !== 1) begin nfail++; $display("FAIL all3_frame[%0d]: got shift=%0d eop=%0d done=%0d want %0d/2/1", k, o_shift, o_eop, o_done, exp_len[k]); end
    end
  endtask

  task automatic test_rr_fairness;
    int exp_which [4] = '{2, 4, 2, 4};
    dat_len = 10'd3; hs_len = 10'd3;
    dat_req = 1; hs_req = 1;
    for (int k = 0; k < 4; k++) begin
      observe_pkt(1, 0);
      ntests++; if (o_which !== exp_which[k] || o_shift !== 3) begin nfail++; $display("FAIL rr_grant[%0d]: got which=%0d shift=%0d want %0d/3", k, o_which, o_shift, exp_which[k]); end
    end
    dat_req = 0; hs_req = 0;
    repeat (3) @(negedge clk);
    ntests++; if (busy !== 1'b0) begin nfail++; $display("FAIL rr_idle_busy: got %b want 0", busy); end
    ntests++; if (sel !== 2'b10) begin nfail++; $display("FAIL idle_sel_hold: got %b want 10", sel); end
  endtask

  task automatic test_zero_len;
    dat_len = 10'd0; dat_req = 1;
    observe_pkt(0, 0);
    ntests++; if (o_which !== 2) begin nfail++; $display("FAIL zlen_which: got %0d want 2", o_which); end
    ntests++; if (o_shift !== 0) begin nfail++; $display("FAIL zlen_shift: got %0d want 0", o_shift); end
    ntests++; if (o_eop !== 2) begin nfail++; $display("FAIL zlen_eop: got %0d want 2", o_eop); end
    ntests++; if (o_done !== 1 || o_gap !== 1) begin nfail++; $display("FAIL zlen_done: got done=%0d gap=%0d want 1/1", o_done, o_gap); end
  endtask

  task automatic test_len_change;
    tok_len = 10'd32; tok_req = 1;
    observe_pkt(0, 1);
    ntests++; if (o_which !== 1) begin nfail++; $display("FAIL lenchg_which: got %0d want 1", o_which); end
    ntests++; if (o_shift !== 32 || o_done !== 1) begin nfail++; $display("FAIL lenchg_shift: got %0d done=%0d want 32/1", o_shift, o_done); end
  endtask

  task automatic test_max_len;
    hs_len = 10'd1023; hs_req = 1;
    observe_pkt(0, 0);
    ntests++; if (o_which !== 4) begin nfail++; $display("FAIL maxlen_which: got %0d want 4", o_which); end
    ntests++; if (o_shift !== 1023 || o_eop !== 2 || o_done !== 1) begin nfail++; $display("FAIL maxlen_frame: got shift=%0d eop=%0d done=%0d want 1023/2/1", o_shift, o_eop, o_done); end
  endtask

  task automatic test_reset_mid_packet;
    bit got;
    bit saw_done;
    int ns;
    dat_len = 10'd544; dat_req = 1; got = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (dat_gnt) begin got = 1; dat_req = 0; break; end
    end
    ntests++; if (!got) begin nfail++; $display("FAIL rstmid_gnt: got none want dat_gnt"); end
    ns = 0; saw_done = 0;
    for (int c = 0; c < 20 && ns < 10; c++) begin
      @(negedge clk);
      if (shift) ns++;
      if (pkt_done) saw_done = 1;
    end
    ntests++; if (ns !== 10 || saw_done) begin nfail++; $display("FAIL rstmid_send: got shifts=%0d done=%0d want 10/0", ns, saw_done); end
    rst_n = 1'b0;
    #1;
    ntests++; if ({tok_gnt, dat_gnt, hs_gnt, shift, eop, busy, pkt_done} !== 7'b0) begin nfail++; $display("FAIL rstmid_outs: got %b want 0000000", {tok_gnt, dat_gnt, hs_gnt, shift, eop, busy, pkt_done}); end
    ntests++; if (sel !== 2'b01) begin nfail++; $display("FAIL rstmid_sel: got %b want 01", sel); end
    @(negedge clk);
    rst_n = 1'b1;
    dat_len = 10'd4; hs_len = 10'd4; dat_req = 1; hs_req = 1;
    observe_pkt(0, 0);
    ntests++; if (o_which !== 2 || o_shift !== 4) begin nfail++; $display("FAIL rstmid_ptr: got which=%0d shift=%0d want 2/4", o_which, o_shift); end
    dat_req = 0; hs_req = 0;
  endtask

  initial begin
    test_reset();
    test_single_token();
    test_all_three();
    test_rr_fairness();
    test_zero_len();
    test_len_change();
    test_max_len();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
